i2c_master: RTL



---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_if.sv | 24 ++
 rtl/i2c_clk_gen.sv | 34 +++
 rtl/i2c_master.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM encoding, quarter-phase indices, slave addresses
// and the SCL/SDA line pattern for each slot quarter.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWrData,
        StRdData,
        StDataAck,
        StStop
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] MEM_SLAVE_ADDR = 7'h1F;
    localparam logic [6:0] NO_SLAVE_ADDR  = 7'h22;

    // Returns {scl, sda} for quarter q of a slot belonging to state st.
    function automatic logic [1:0] bus_lines(i2c_state_e st, logic [1:0] q, logic sda_bit);
        case (st)
            StIdle:  bus_lines = 2'b11;
            StStart: bus_lines = {q != Q3, q == Q0};
            StStop:  bus_lines = {q != Q0, q >= Q2};
            default: bus_lines = {(q == Q1) || (q == Q2), sda_bit};
        endcase
    endfunction

endpackage

// File: rtl/i2c_if.sv
// System-side request/response and split serial lines of the single-byte I2C master.
interface i2c_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       SCL_O;
    logic       SDA_O;
    logic       SDA_I;

    modport master (
        input  start, rw, addr, wdata, SDA_I,
        output rdata, busy, done, ack_err, SCL_O, SDA_O
    );

    modport slave (
        output start, rw, addr, wdata, SDA_I,
        input  rdata, busy, done, ack_err, SCL_O, SDA_O
    );
endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: one-cycle qtick every CLK_DIV clocks plus a 2-bit
// quarter index, held at zero while disabled and restarted on accept.
module i2c_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] quarter
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign qtick = en && !clr && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            quarter <= '0;
        end else if (clr || !en) begin
            cnt     <= '0;
            quarter <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address byte, one data byte (write or read) and STOP,
// with SCL derived from the system clock and all bus lines registered.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input logic   clk,
    input logic   rst,
    i2c_if.master bus
);
    i2c_state_e state;
    logic [7:0] shreg;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic [2:0] bit_cnt;
    logic       rw_q;
    logic       sda_smp;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic       scl_q;
    logic       sda_q;

    logic       qtick;
    logic [1:0] quarter;
    logic       accept;
    logic       slot_end;
    logic       sample;
    logic       tx_bit;

    assign accept   = (state == StIdle) && bus.start;
    assign slot_end = qtick && (quarter == Q3);
    assign sample   = qtick && (quarter == Q1);
    // Only address and write-data slots drive data; every other slot leaves SDA released.
    assign tx_bit   = ((state == StAddr) || (state == StWrData)) ? shreg[7] : 1'b1;

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (busy_q),
        .qtick   (qtick),
        .quarter (quarter)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            shreg     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bit_cnt   <= '0;
            rw_q      <= 1'b0;
            sda_smp   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            // Mid SCL-high sample point.
            if (sample) begin
                sda_smp <= bus.SDA_I;
                if (state == StRdData) shreg <= {shreg[6:0], bus.SDA_I};
            end
            if (qtick && !slot_end) begin
                {scl_q, sda_q} <= bus_lines(state, quarter + 2'd1, tx_bit);
            end
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        shreg     <= {bus.addr, bus.rw};
                        rw_q      <= bus.rw;
                        wdata_q   <= bus.wdata;
                        ack_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= StStart;
                    end
                end
                StStart: begin
                    if (slot_end) begin
                        state          <= StAddr;
                        bit_cnt        <= 3'd7;
                        {scl_q, sda_q} <= bus_lines(StAddr, Q0, shreg[7]);
                    end
                end
                StAddr, StWrData: begin
                    if (slot_end) begin
                        if (bit_cnt == 3'd0) begin
                            state          <= (state == StAddr) ? StAddrAck : StDataAck;
                            {scl_q, sda_q} <= bus_lines(StAddrAck, Q0, 1'b1);
                        end else begin
                            bit_cnt        <= bit_cnt - 3'd1;
                            shreg          <= {shreg[6:0], 1'b0};
                            {scl_q, sda_q} <= bus_lines(state, Q0, shreg[6]);
                        end
                    end
                end
                StAddrAck: begin
                    if (slot_end) begin
                        if (sda_smp) begin
                            ack_err_q      <= 1'b1;
                            state          <= StStop;
                            {scl_q, sda_q} <= bus_lines(StStop, Q0, 1'b1);
                        end else if (rw_q) begin
                            state          <= StRdData;
                            bit_cnt        <= 3'd7;
                            {scl_q, sda_q} <= bus_lines(StRdData, Q0, 1'b1);
                        end else begin
                            state          <= StWrData;
                            bit_cnt        <= 3'd7;
                            shreg          <= wdata_q;
                            {scl_q, sda_q} <= bus_lines(StWrData, Q0, wdata_q[7]);
                        end
                    end
                end
                StRdData: begin
                    if (slot_end) begin
                        if (bit_cnt == 3'd0) state <= StDataAck;
                        else bit_cnt <= bit_cnt - 3'd1;
                        {scl_q, sda_q} <= bus_lines(StRdData, Q0, 1'b1);
                    end
                end
                StDataAck: begin
                    if (slot_end) begin
                        if (rw_q) rdata_q <= shreg;
                        else if (sda_smp) ack_err_q <= 1'b1;
                        state          <= StStop;
                        {scl_q, sda_q} <= bus_lines(StStop, Q0, 1'b1);
                    end
                end
                StStop: begin
                    if (slot_end) begin
                        state          <= StIdle;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        {scl_q, sda_q} <= 2'b11;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.SCL_O   = scl_q;
    assign bus.SDA_O   = sda_q;
endmodule
